// File: rtl/controller_fsm_mc_if.sv
// rtl/controller_fsm_mc_if.sv - control bundle between the multicycle controller and its datapath
// Optional macro CTRL_MEM_WAIT_EN adds the mem_ready handshake signal.
interface controller_fsm_mc_if;
    logic [6:0] op;
    logic       zero;
`ifdef CTRL_MEM_WAIT_EN
    logic       mem_ready;
`endif
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       RegWrite;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
`ifdef CTRL_MEM_WAIT_EN
        input  mem_ready,
`endif
        input  op, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, RegWrite, instr_done, illegal_op, state
    );

    modport slave (
`ifdef CTRL_MEM_WAIT_EN
        output mem_ready,
`endif
        output op, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, RegWrite, instr_done, illegal_op, state
    );
endinterface

// File: rtl/controller_fsm_mc.sv
// rtl/controller_fsm_mc.sv - main control FSM of the multicycle RV32 core (lw, sw, R/I ALU, beq, jal)
// Optional macro CTRL_MEM_WAIT_EN stalls FETCH/MEMREAD/MEMWRITE on mem_ready.
module controller_fsm_mc #(
    parameter int ILLEGAL_HALT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    controller_fsm_mc_if.master    bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t     r_state;
    state_t     w_next;
    logic       w_mem_ready;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_adr_src;
    logic       w_mem_write;
    logic       w_ir_write;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_instr_done;
    logic       w_illegal_op;

`ifdef CTRL_MEM_WAIT_EN
    assign w_mem_ready = bus.mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next       = S_FETCH;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_reg_write  = 1'b0;
        w_instr_done = 1'b0;
        w_illegal_op = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = w_mem_ready;
                w_pc_update  = w_mem_ready;
                w_next       = w_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default: begin
                        w_illegal_op = 1'b1;
                        if (ILLEGAL_HALT != 0) begin
                            w_next = S_HALT;
                        end else begin
                            w_next       = S_FETCH;
                            w_instr_done = 1'b1;
                        end
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                w_next    = w_mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_mem_write  = 1'b1;
                w_instr_done = w_mem_ready;
                w_next       = w_mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BEQ: begin
                w_alu_src_a  = 2'b10;
                w_alu_op     = 2'b01;
                w_branch     = 1'b1;
                w_instr_done = 1'b1;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Reset gates every output so no write enable can leak in a reset cycle.
    assign bus.PCWrite    = rst_n & (w_pc_update | (w_branch & bus.zero));
    assign bus.AdrSrc     = rst_n & w_adr_src;
    assign bus.MemWrite   = rst_n & w_mem_write;
    assign bus.IRWrite    = rst_n & w_ir_write;
    assign bus.ResultSrc  = rst_n ? w_result_src : 2'b00;
    assign bus.ALUSrcA    = rst_n ? w_alu_src_a : 2'b00;
    assign bus.ALUSrcB    = rst_n ? w_alu_src_b : 2'b00;
    assign bus.ALUOp      = rst_n ? w_alu_op : 2'b00;
    assign bus.RegWrite   = rst_n & w_reg_write;
    assign bus.instr_done = rst_n & w_instr_done;
    assign bus.illegal_op = rst_n & w_illegal_op;
    assign bus.state      = rst_n ? r_state : 4'd0;
endmodule

// File: tb/tb_controller_fsm_mc.sv
// tb/tb_controller_fsm_mc.sv - directed table-driven bench for controller_fsm_mc
module tb_controller_fsm_mc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_n_h;

    controller_fsm_mc_if bus();
    controller_fsm_mc_if hbus();

    controller_fsm_mc #(.ILLEGAL_HALT(0)) u_dut  (.clk(clk), .rst_n(rst_n),   .bus(bus.master));
    controller_fsm_mc #(.ILLEGAL_HALT(1)) u_halt (.clk(clk), .rst_n(rst_n_h), .bus(hbus.master));

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic        zero;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic [18:0] w_act;
    logic [18:0] w_hact;
    assign w_act  = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                     bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.instr_done,
                     bus.illegal_op, bus.state};
    assign w_hact = {hbus.PCWrite, hbus.AdrSrc, hbus.MemWrite, hbus.IRWrite, hbus.ResultSrc,
                     hbus.ALUSrcA, hbus.ALUSrcB, hbus.ALUOp, hbus.RegWrite, hbus.instr_done,
                     hbus.illegal_op, hbus.state};

    // Word layout: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,RegWrite,instr_done,illegal_op,state}
    function automatic logic [18:0] mk(input logic [3:0] st, input logic pcw, input logic adr,
                                       input logic mw, input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] ao,
                                       input logic rw, input logic done, input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, ao, rw, done, ill, st};
    endfunction

    task automatic add(input string n, input logic [6:0] o, input logic z, input logic [18:0] e);
        vec_t v;
        v.name = n;
        v.op   = o;
        v.zero = z;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string n, input logic [18:0] a, input logic [18:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic step(input string n, input logic [6:0] o, input logic z, input logic [18:0] e);
        bus.op   = o;
        bus.zero = z;
        @(negedge clk);
        chk(n, w_act, e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic [18:0] F, D, MA, MR, MWB, MW, ER, EI, AWB, BQ1, BQ0, J, DI, DIH, H;
`ifdef CTRL_MEM_WAIT_EN
    logic [18:0] MWW, FW;
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        F   = mk(4'd0,  1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
        D   = mk(4'd1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 0);
        MA  = mk(4'd2,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0);
        MR  = mk(4'd3,  0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        MWB = mk(4'd4,  0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        MW  = mk(4'd5,  0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        ER  = mk(4'd6,  0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0);
        EI  = mk(4'd7,  0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0);
        AWB = mk(4'd8,  0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        BQ1 = mk(4'd9,  1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 1, 0);
        BQ0 = mk(4'd9,  0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 1, 0);
        J   = mk(4'd10, 1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0);
        DI  = mk(4'd1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 1, 1);
        DIH = mk(4'd1,  0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 1);
        H   = mk(4'd11, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
`ifdef CTRL_MEM_WAIT_EN
        MWW = mk(4'd5,  0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        FW  = mk(4'd0,  0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
        bus.mem_ready  = 1'b1;
        hbus.mem_ready = 1'b1;
`endif

        add("lw_fetch", LW, 0, F);   add("lw_decode", LW, 0, D);  add("lw_memadr", LW, 0, MA);
        add("lw_memread", LW, 0, MR); add("lw_memwb", LW, 0, MWB);
        add("sw_fetch", SW, 0, F);   add("sw_decode", SW, 0, D);  add("sw_memadr", SW, 0, MA);
        add("sw_memwrite", SW, 0, MW);
        add("r_fetch", RT, 0, F);    add("r_decode", RT, 0, D);   add("r_exec", RT, 0, ER);
        add("r_aluwb", RT, 0, AWB);
        add("i_fetch", IT, 0, F);    add("i_decode", IT, 0, D);   add("i_exec", IT, 0, EI);
        add("i_aluwb", IT, 0, AWB);
        add("beq1_fetch", BQ, 1, F); add("beq1_decode", BQ, 1, D); add("beq1_taken", BQ, 1, BQ1);
        add("beq0_fetch", BQ, 0, F); add("beq0_decode", BQ, 0, D); add("beq0_nottaken", BQ, 0, BQ0);
        add("jal_fetch", JL, 0, F);  add("jal_decode", JL, 0, D);  add("jal_jal", JL, 0, J);
        add("jal_aluwb", JL, 0, AWB);
        add("bad_fetch", BAD, 0, F); add("bad_decode", BAD, 0, DI);
        add("after_bad_fetch", LW, 0, F);

        rst_n     = 1'b0;
        rst_n_h   = 1'b0;
        bus.op    = 7'd0;
        bus.zero  = 1'b0;
        hbus.op   = BAD;
        hbus.zero = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_main", w_act, 19'd0);
        chk("reset_halt", w_hact, 19'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) step(vecs[i].name, vecs[i].op, vecs[i].zero, vecs[i].exp);

        // lw already in FETCH from the last row: walk to MEMREAD, then reset there.
        step("mid_decode", LW, 0, D);
        step("mid_memadr", LW, 0, MA);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_memread_c1", w_act, 19'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_memread_c2", w_act, 19'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("post_rst_fetch", SW, 0, F);
        step("post_rst_decode", SW, 0, D);
        step("post_rst_memadr", SW, 0, MA);
`ifdef CTRL_MEM_WAIT_EN
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) step("sw_wait", SW, 0, MWW);
        bus.mem_ready = 1'b1;
`endif
        step("post_rst_memwrite", SW, 0, MW);
`ifdef CTRL_MEM_WAIT_EN
        bus.mem_ready = 1'b0;
        step("fetch_wait", SW, 0, FW);
        bus.mem_ready = 1'b1;
`endif
        step("post_rst_fetch2", SW, 0, F);

        rst_n_h = 1'b1;
        @(negedge clk);
        chk("halt_fetch", w_hact, F);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("halt_decode", w_hact, DIH);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            hbus.op = (k % 2 == 0) ? LW : BAD;
            @(negedge clk);
            chk("halt_hold", w_hact, H);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/controller_fsm_mc.md
Name: controller_fsm_mc

Overview:
Main control FSM for the multicycle RV32 core. It sequences the shared datapath (PC, IR, register file, ALU, unified memory) through fetch, decode and execute steps. It drives the 2-bit ALUOp consumed by the ALU decoder, and all mux selects and write enables. Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
ILLEGAL_HALT, 0, 0: an unknown opcode is skipped (back to FETCH); 1: the FSM enters HALT and stays there until reset.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous reset, active-low
op  input  7  instruction opcode, IR[6:0]
zero  input  1  ALU zero flag
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
MemWrite  output  1  memory write enable
IRWrite  output  1  IR and OldPC enable
ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  output  2  00 = RD2, 01 = ImmExt, 10 = constant 4
ALUOp  output  2  00 = add, 01 = sub/branch, 10 = decode by funct fields
RegWrite  output  1  register file write enable
instr_done  output  1  pulse in the last cycle of each instruction
illegal_op  output  1  pulse in DECODE when op is unsupported
state  output  4  current state encoding (debug)

Behaviour:
- One clock (clk). Reset is synchronous and active-low: on a rising clk edge with rst_n=0, the state register loads FETCH.
- While rst_n=0: all outputs forced to 0, including the write enables, instr_done and illegal_op.
- Outputs are Moore, decoded from the state register. The one exception is PCWrite = PCUpdate | (Branch & zero), which is combinational on zero.
- Any output not listed for a state below is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10, HALT=11. Encodings 12-15 are unreachable; if entered, next state is FETCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes branch/jump target).
  - op 0000011 or 0100011 -> MEMADR
  - op 0110011 -> EXECUTER
  - op 0010011 -> EXECUTEI
  - op 1100011 -> BEQ
  - op 1101111 -> JAL
  - any other op -> illegal_op=1; next is FETCH with instr_done=1 (ILLEGAL_HALT=0), or HALT (ILLEGAL_HALT=1).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, instr_done=1. Next: FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1. Next: FETCH.
- HALT: all outputs 0 except state. Exits only via reset.
- op is sampled every cycle; the IR holds it stable from DECODE to end of instruction.
- Latency in cycles: lw 5, sw 4, R/I 4, jal 4, beq 3.
- Reset mid-instruction: the next cycle is FETCH, with no partial write-enable pulse in the reset cycle.

Optional Feature:
Macro CTRL_MEM_WAIT_EN.
- Defined:
  - Adds input port mem_ready (1 bit).
  - FETCH holds while mem_ready=0, with IRWrite=0 and PCUpdate=0; it advances and asserts both only in the cycle mem_ready=1.
  - MEMREAD holds until mem_ready=1.
  - MEMWRITE keeps MemWrite=1 each cycle until mem_ready=1; instr_done is asserted only in that final cycle.
- Undefined: no mem_ready port; behaviour equals mem_ready tied to 1.

Test Plan:
- rst_n=0 for 2 cycles mid-MEMREAD, then released -> all outputs 0 during reset; state=0, IRWrite=1 and PCWrite=1 in the first cycle after.
- lw (op=0000011) -> state sequence 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in state 4; instr_done single pulse.
- beq with zero=1, then with zero=0 -> in BEQ, ALUOp=01 and PCWrite=1 / PCWrite=0 respectively; returns to FETCH after 3 cycles.
- jal (op=1101111) -> sequence 0,1,10,8,0; PCWrite=1 in JAL; RegWrite=1 in ALUWB with ResultSrc=00.
- op=1111111 -> illegal_op pulse in DECODE, then FETCH (ILLEGAL_HALT=0); with ILLEGAL_HALT=1 -> state=11 held for 20 cycles, all enables 0.
- CTRL_MEM_WAIT_EN, sw with mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles, instr_done only in the 4th.
